ibex_xif_rf_wb_arbiter: RTL



---
 rtl/ibex_xif_rf_wb_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ibex_xif_rf_wb_arbiter.sv
// Register-file write-port arbiter between core writeback and XIF results, with an
// outstanding-destination scoreboard. Starvation guard: IBEX_XIF_RF_ARB_STARVE_GUARD_EN.
module ibex_xif_rf_wb_arbiter #(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MaxWait   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 core_we_i,
  input  logic [4:0]           core_waddr_i,
  input  logic [DataWidth-1:0] core_wdata_i,
  output logic                 core_stall_o,
  input  logic                 xif_issue_valid_i,
  input  logic [4:0]           xif_issue_rd_i,
  input  logic                 xif_result_valid_i,
  output logic                 xif_result_ready_o,
  input  logic [4:0]           xif_result_rd_i,
  input  logic [DataWidth-1:0] xif_result_data_i,
  input  logic                 xif_result_we_i,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic                 hazard_o,
  output logic [(RV32E ? 16 : 32)-1:0] pending_o,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 err_o
);

  localparam int unsigned AW   = RV32E ? 4 : 5;
  localparam int unsigned NREG = 1 << AW;

  // Under RV32E, any address with bit 4 set names a register that does not exist.
  function automatic logic rd_ok(input logic [4:0] rd);
    return !RV32E || !rd[4];
  endfunction

  logic core_req;
  logic stall, ready;
  logic xif_hs, core_wr, xif_wr, res_ok;

  assign core_req = core_we_i & (core_waddr_i != 5'd0);

`ifdef IBEX_XIF_RF_ARB_STARVE_GUARD_EN
  typedef enum logic [1:0] {ARB, WAIT, FORCE} state_e;

  localparam logic [3:0] MW = 4'(MaxWait);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = !core_req;
    stall   = 1'b0;
    case (state_q)
      ARB, WAIT: begin
        // A blocked cycle is a pending result with the core holding the port.
        if (xif_result_valid_i && core_req) begin
          cnt_d   = cnt_q + 4'd1;
          state_d = (cnt_d == MW) ? FORCE : WAIT;
        end else begin
          cnt_d   = 4'd0;
          state_d = ARB;
        end
      end
      FORCE: begin
        ready   = 1'b1;
        stall   = 1'b1;
        cnt_d   = 4'd0;
        state_d = ARB;
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = ARB;
      end
    endcase
  end
`else
  assign ready = !core_req;
  assign stall = 1'b0;
`endif

  assign core_stall_o       = stall;
  assign xif_result_ready_o = ready;

  assign xif_hs  = xif_result_valid_i & ready;
  assign res_ok  = rd_ok(xif_result_rd_i);
  assign core_wr = core_req & !stall;
  assign xif_wr  = xif_hs & res_ok & xif_result_we_i & (xif_result_rd_i != 5'd0);

  logic src_xif_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= 5'd0;
      rf_wdata_o <= '0;
      src_xif_q  <= 1'b0;
    end else begin
      rf_we_o   <= core_wr | xif_wr;
      src_xif_q <= !core_wr & xif_wr;
      if (core_wr) begin
        rf_waddr_o <= core_waddr_i;
        rf_wdata_o <= core_wdata_i;
      end else if (xif_wr) begin
        rf_waddr_o <= xif_result_rd_i;
        rf_wdata_o <= xif_result_data_i;
      end
    end
  end

  // Scoreboard
  logic [NREG-1:0] pending_q, pending_d, set_mask, clr_mask;
  logic [AW-1:0]   iss_idx, res_idx;
  logic            iss_ok, clr, err_d;

  assign iss_idx = xif_issue_rd_i[AW-1:0];
  assign res_idx = xif_result_rd_i[AW-1:0];
  assign iss_ok  = xif_issue_valid_i & rd_ok(xif_issue_rd_i) & (xif_issue_rd_i != 5'd0);
  assign clr     = xif_hs & res_ok & (xif_result_rd_i != 5'd0);

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (iss_ok) set_mask[iss_idx] = 1'b1;
    if (clr)    clr_mask[res_idx] = 1'b1;
    // Set wins over clear so a same-cycle reissue of rd keeps it pending.
    pending_d = (pending_q & ~clr_mask) | set_mask;
  end

  always_comb begin
    err_d = 1'b0;
    if (iss_ok && pending_q[iss_idx] && !(clr && res_idx == iss_idx)) err_d = 1'b1;
    if (clr && !pending_q[res_idx])                                   err_d = 1'b1;
    if (xif_issue_valid_i && !rd_ok(xif_issue_rd_i))                  err_d = 1'b1;
    if (xif_hs && !res_ok)                                            err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
      err_o     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      err_o     <= err_d;
    end
  end

  assign pending_o = pending_q;

  // An XIF result sitting in the output register is not yet visible to RF reads.
  logic fwd_xif, hz_a, hz_b;

  assign fwd_xif = rf_we_o & src_xif_q;
  assign hz_a = (raddr_a_i != 5'd0) &
                ((rd_ok(raddr_a_i) & pending_q[raddr_a_i[AW-1:0]]) |
                 (fwd_xif & (rf_waddr_o == raddr_a_i)));
  assign hz_b = (raddr_b_i != 5'd0) &
                ((rd_ok(raddr_b_i) & pending_q[raddr_b_i[AW-1:0]]) |
                 (fwd_xif & (rf_waddr_o == raddr_b_i)));
  assign hazard_o = hz_a | hz_b;

endmodule
